// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared serial bus: one-hot registered grant,
// release on request drop, idle timeout or tenure preemption, one-cycle turnaround.
module bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int MID_WIDTH   = 2,
    parameter int TIMEOUT_LEN = 6,
    parameter int TENURE_LEN  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] b_request,
    input  logic                   b_bus_utilizing,
    output logic [NUM_MASTERS-1:0] b_grant,
    output logic [MID_WIDTH-1:0]   cur_master,
    output logic                   arb_busy,
    output logic                   timeout_pulse,
    output logic                   proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_RELEASE
    } state_t;

    localparam logic [MID_WIDTH:0]     NM   = (MID_WIDTH+1)'(NUM_MASTERS);
    localparam logic [MID_WIDTH-1:0]   LAST = MID_WIDTH'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ONE  = NUM_MASTERS'(1);

    state_t                 r_state, w_state_nx;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nx;
    logic [MID_WIDTH-1:0]   r_cur, w_cur_nx;
    logic [MID_WIDTH-1:0]   r_ptr, w_ptr_nx;
    logic                   r_busy, w_busy_nx;
    logic                   r_timeout, w_timeout_nx;
    logic                   r_perr, w_perr_nx;
    logic [TIMEOUT_LEN-1:0] r_idle, w_idle_nx;
    logic [TENURE_LEN-1:0]  r_ten, w_ten_nx;

    logic [NUM_MASTERS-1:0] w_rot;
    logic [NUM_MASTERS-1:0] w_onehot;
    logic [MID_WIDTH-1:0]   w_off;
    logic [MID_WIDTH:0]     w_sum;
    logic [MID_WIDTH-1:0]   w_winner;
    logic                   w_found;
    logic                   w_own_req;
    logic                   w_others;
    logic                   w_release;

    // Rotate requests so bit 0 is the pointer position, take the lowest set bit,
    // then rotate the offset back into an absolute master index.
    always_comb begin
        w_rot = (b_request >> r_ptr) | (b_request << (NUM_MASTERS - int'(r_ptr)));
        w_off = '0;
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = MID_WIDTH'(j);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= NM) begin
            w_sum = w_sum - NM;
        end
        w_winner  = w_sum[MID_WIDTH-1:0];
        w_onehot  = ONE << w_winner;
        w_found   = |b_request;
        w_own_req = |(b_request & r_grant);
        w_others  = |(b_request & ~r_grant);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_cur     <= '0;
            r_ptr     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_perr    <= 1'b0;
            r_idle    <= '0;
            r_ten     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_grant   <= w_grant_nx;
            r_cur     <= w_cur_nx;
            r_ptr     <= w_ptr_nx;
            r_busy    <= w_busy_nx;
            r_timeout <= w_timeout_nx;
            r_perr    <= w_perr_nx;
            r_idle    <= w_idle_nx;
            r_ten     <= w_ten_nx;
        end
    end

    // Releases only happen on a quiet bus so an in-flight transfer is never cut.
    always_comb begin
        w_state_nx   = r_state;
        w_grant_nx   = r_grant;
        w_cur_nx     = r_cur;
        w_ptr_nx     = r_ptr;
        w_busy_nx    = r_busy;
        w_timeout_nx = 1'b0;
        w_perr_nx    = r_perr | (b_bus_utilizing & (r_state != ST_GRANTED));
        w_idle_nx    = r_idle;
        w_ten_nx     = r_ten;
        w_release    = 1'b0;

        case (r_state)
            ST_IDLE, ST_RELEASE: begin
                if (w_found && !b_bus_utilizing) begin
                    w_state_nx = ST_GRANTED;
                    w_grant_nx = w_onehot;
                    w_cur_nx   = w_winner;
                    w_busy_nx  = 1'b1;
                    w_idle_nx  = '0;
                    w_ten_nx   = '0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_GRANTED: begin
                w_idle_nx = b_bus_utilizing ? '0 : r_idle + TIMEOUT_LEN'(1);
                w_ten_nx  = (&r_ten) ? r_ten : r_ten + TENURE_LEN'(1);
                if (!b_bus_utilizing) begin
                    if (!w_own_req) begin
                        w_release = 1'b1;
                    end else if (&r_idle) begin
                        w_release    = 1'b1;
                        w_timeout_nx = 1'b1;
                    end else if ((&r_ten) && w_others) begin
                        w_release = 1'b1;
                    end
                end
                if (w_release) begin
                    w_state_nx = ST_RELEASE;
                    w_grant_nx = '0;
                    w_cur_nx   = '0;
                    w_busy_nx  = 1'b0;
                    w_ptr_nx   = (r_cur == LAST) ? '0 : r_cur + MID_WIDTH'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_grant_nx = '0;
                w_cur_nx   = '0;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    assign b_grant       = r_grant;
    assign cur_master    = r_cur;
    assign arb_busy      = r_busy;
    assign timeout_pulse = r_timeout;
    assign proto_err     = r_perr;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Central arbiter for the shared serial bus. It accepts `b_request` lines from up to `NUM_MASTERS` masters and issues a one-hot registered `b_grant` using round-robin priority. It watches `b_bus_utilizing` to learn when the granted master is mid-transaction. It withdraws the grant when the master releases its request, when the master idles past a timeout, or when the master's tenure expires while others are waiting. It sits beside the masters and slaves on the bus and replaces the hand-driven grant used in master/slave benches.

## Interface
Parameters:
- `NUM_MASTERS`, 3: number of requesting masters (2..8).
- `MID_WIDTH`, 2: width of `cur_master`; must satisfy 2^MID_WIDTH >= NUM_MASTERS.
- `TIMEOUT_LEN`, 6: idle-timeout counter width in bits; the timeout fires after 2^TIMEOUT_LEN−1 consecutive idle granted cycles.
- `TENURE_LEN`, 8: tenure counter width in bits; preemption becomes eligible after 2^TENURE_LEN−1 granted cycles.

Ports:
- `clk`  in  1  bus clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `b_request`  in  NUM_MASTERS  per-master bus request; level, held for the whole tenure.
- `b_bus_utilizing`  in  1  wired bus-utilizing line; high while any master is mid-transaction.
- `b_grant`  out  NUM_MASTERS  one-hot registered grant, or all zero.
- `cur_master`  out  MID_WIDTH  index of the granted master; 0 when no grant is active.
- `arb_busy`  out  1  high whenever a grant is active.
- `timeout_pulse`  out  1  one-cycle pulse when a grant is revoked by the idle timeout.
- `proto_err`  out  1  sticky flag: `b_bus_utilizing` was seen high with no grant active. Cleared only by `rst`.

## Operation
- FSM states: IDLE, GRANTED, RELEASE.
- Round-robin pointer `ptr`:
  - The winner is the first requesting index found scanning `ptr`, `ptr+1`, … with modulo-NUM_MASTERS wrap.
  - On every release, `ptr` ← winner+1, wrapping to 0 after NUM_MASTERS−1.
- IDLE:
  - If `b_request != 0` and `b_bus_utilizing == 0`: go to GRANTED and register the winner's grant bit, `cur_master`, and `arb_busy = 1`. Clear both counters.
  - If `b_bus_utilizing == 1`: stay in IDLE, grant nothing, set `proto_err`.
- GRANTED: the grant is held constant. Counters:
  - `idle_cnt` clears when `b_bus_utilizing == 1`; otherwise it increments.
  - `tenure_cnt` increments every cycle and saturates at all-ones.
- GRANTED release conditions, evaluated in priority order. Each takes effect only when `b_bus_utilizing == 0`; an in-flight transaction is never cut.
  1. The granted master's request is low.
  2. `idle_cnt` is all-ones. This also pulses `timeout_pulse`.
  3. `tenure_cnt` is all-ones and some other master is requesting (preemption).
- On release: go to RELEASE, drive `b_grant` to 0, drive `arb_busy` to 0, and update `ptr`.
- RELEASE lasts exactly one cycle with the grant low (turnaround). At its edge, if a winner exists and `b_bus_utilizing == 0`, go to GRANTED with the new winner; otherwise go to IDLE.
- The granted master's request dropping while `b_bus_utilizing == 1`: hold the grant until utilizing falls, then release.
- A timed-out or preempted master that keeps requesting stays eligible and is re-granted in its round-robin turn.
- Only one `b_grant` bit is ever high. `b_grant` is never high during RELEASE.

## Timing
- Reset values: `b_grant = 0`, `cur_master = 0`, `arb_busy = 0`, `timeout_pulse = 0`, `proto_err = 0`, `ptr = 0`, state IDLE, counters 0.
- Grant latency: a request sampled high at edge n in IDLE (bus idle) gives `b_grant` high after edge n. That is 1 cycle of latency.
- Release latency: a release condition true at edge n gives the grant low after edge n.
- Handover: the next grant rises after edge n+1. The bus therefore sees exactly one grant-free cycle between masters.
- Timeout: with the bus idle from the grant edge onward, the grant falls 2^TIMEOUT_LEN cycles after it rose. `timeout_pulse` is high in the same cycle the grant first reads low.
- `rst` asserted mid-tenure: all outputs return to reset values at the next edge, regardless of bus state.

## Test plan
- Single master (NUM_MASTERS=3): `b_request=3'b001` at edge 0 → `b_grant=3'b001` and `cur_master=0` from edge 0. Drop the request at edge 10 → grant 0 after edge 10; IDLE.
- Round-robin: all three request continuously, each dropping its request 5 cycles after being granted → grant order 0,1,2,0 with one zero-grant cycle between each.
- Hold during transfer: master 1 drops its request while `b_bus_utilizing=1` for 4 more cycles → grant stays 3'b010 until utilizing falls, then drops the next edge.
- Timeout, TIMEOUT_LEN=4: master 2 is granted and never drives utilizing → grant falls 16 cycles after rising, `timeout_pulse` is high 1 cycle, and master 0 (also requesting) is granted the cycle after RELEASE.
- Preemption, TENURE_LEN=5: master 0 holds its request with short utilizing bursts while master 1 requests → after 31 granted cycles, at the first utilizing-low cycle, the grant moves to master 1 via one RELEASE cycle.
- Protocol error and reset: `b_bus_utilizing=1` in IDLE with `b_request=3'b100` → no grant, `proto_err=1` sticky. Assert `rst` for one edge mid-tenure → all outputs return to 0.
